// File: rtl/bounce_gen.sv
// rtl/bounce_gen.sv - emulated bouncy push-button source for debouncer stimulus
// On request, y reaches the target level through LFSR-timed glitches, then holds.
module bounce_gen #(
  parameter logic [15:0] BOUNCE_CYCLES = 16'd2000,
  parameter int          GAP_BITS      = 4,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       level,
  output logic       ready,
  output logic       y,
  output logic       settled,
  output logic [7:0] bounce_count
);

  // An all-zero Fibonacci LFSR would lock up, so a zero seed is swapped out.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [15:0] WIN_LAST = BOUNCE_CYCLES - 16'd1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BOUNCE,
    S_SETTLE
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [15:0]       win_q, win_d;
  logic [GAP_BITS:0] gap_q, gap_d;
  logic [GAP_BITS:0] gap_new;
  logic              y_q, y_d;
  logic              tgt_q, tgt_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        cnt_inc;

  assign lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign gap_new = {1'b0, lfsr_q[GAP_BITS-1:0]} + (GAP_BITS+1)'(1);
  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED_EFF;
      win_q   <= '0;
      gap_q   <= '0;
      y_q     <= 1'b0;
      tgt_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      win_q   <= win_d;
      gap_q   <= gap_d;
      y_q     <= y_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    gap_d   = gap_q;
    y_d     = y_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          tgt_d = level;
          if (level != y_q) begin
            y_d     = ~y_q;
            cnt_d   = 8'd1;
            win_d   = '0;
            gap_d   = gap_new;
            state_d = S_BOUNCE;
          end else begin
            cnt_d   = '0;
            state_d = S_SETTLE;
          end
        end
      end
      S_BOUNCE: begin
        win_d = win_q + 16'd1;
        // End of window wins over a coincident gap toggle.
        if (win_q == WIN_LAST) begin
          y_d = tgt_q;
          if (y_q != tgt_q) begin
            cnt_d = cnt_inc;
          end
          state_d = S_SETTLE;
        end else if (gap_q == (GAP_BITS+1)'(1)) begin
          y_d   = ~y_q;
          cnt_d = cnt_inc;
          gap_d = gap_new;
        end else begin
          gap_d = gap_q - (GAP_BITS+1)'(1);
        end
      end
      S_SETTLE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ready        = (state_q == S_IDLE);
  assign settled      = (state_q == S_SETTLE);
  assign y            = y_q;
  assign bounce_count = cnt_q;

endmodule

// File: tb/tb_bounce_gen.sv
// tb/tb_bounce_gen.sv - randomized self-checking bench for bounce_gen
// Two instances: a short window and a long window that saturates bounce_count.
module tb_bounce_gen;

  logic       clk = 1'b0;
  logic       rst_v   [2];
  logic       req_v   [2];
  logic       level_v [2];
  logic       ready_v [2];
  logic       y_v     [2];
  logic       settled_v [2];
  logic [7:0] bc_v    [2];

  int          bcs   [2] = '{8, 700};
  int          gbs   [2] = '{2, 1};
  logic [15:0] seeds [2] = '{16'h1234, 16'hACE1};
  logic [15:0] m_lfsr [2];
  logic        m_y    [2];

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  bounce_gen #(.BOUNCE_CYCLES(16'd8), .GAP_BITS(2), .SEED(16'h1234)) dut0 (
    .clk(clk), .rst(rst_v[0]), .req(req_v[0]), .level(level_v[0]),
    .ready(ready_v[0]), .y(y_v[0]), .settled(settled_v[0]), .bounce_count(bc_v[0])
  );

  bounce_gen #(.BOUNCE_CYCLES(16'd700), .GAP_BITS(1), .SEED(16'h0000)) dut1 (
    .clk(clk), .rst(rst_v[1]), .req(req_v[1]), .level(level_v[1]),
    .ready(ready_v[1]), .y(y_v[1]), .settled(settled_v[1]), .bounce_count(bc_v[1])
  );

  function automatic logic [15:0] lstep(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Reference random source: same polynomial, advanced once per clock outside reset.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      m_lfsr[i] <= rst_v[i] ? seeds[i] : lstep(m_lfsr[i]);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_state(input int i);
    check("rst_y", 32'(y_v[i]), 0);
    check("rst_ready", 32'(ready_v[i]), 1);
    check("rst_settled", 32'(settled_v[i]), 0);
    check("rst_count", 32'(bc_v[i]), 0);
  endtask

  task automatic idle(input int i, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      check("idle_y", 32'(y_v[i]), 32'(m_y[i]));
      check("idle_ready", 32'(ready_v[i]), 1);
      check("idle_settled", 32'(settled_v[i]), 0);
    end
  endtask

  // One operation; when noise is set, random req/level are driven while busy.
  task automatic do_op(input int i, input logic lvl, input bit noise);
    logic [15:0] l;
    logic        y0, ey, prev;
    int          offs[$];
    int          t, g, ntog, nedge, par, exp_cnt;
    l  = m_lfsr[i];
    y0 = m_y[i];
    check("op_ready_before", 32'(ready_v[i]), 1);
    req_v[i]   = 1'b1;
    level_v[i] = lvl;
    if (lvl != y0) begin
      t = 0;
      offs.push_back(0);
      forever begin
        g = (int'(l) & ((1 << gbs[i]) - 1)) + 1;
        for (int s = 0; s < g; s++) l = lstep(l);
        t += g;
        if (t > bcs[i] - 1) break;
        offs.push_back(t);
      end
    end
    @(negedge clk);
    if (lvl == y0) begin
      req_v[i] = 1'b0;
      check("nochg_settled", 32'(settled_v[i]), 1);
      check("nochg_y", 32'(y_v[i]), 32'(y0));
      check("nochg_count", 32'(bc_v[i]), 0);
      check("nochg_ready", 32'(ready_v[i]), 0);
      @(negedge clk);
      check("nochg_ready_after", 32'(ready_v[i]), 1);
      check("nochg_y_after", 32'(y_v[i]), 32'(y0));
      return;
    end
    ntog  = offs.size();
    prev  = y0;
    nedge = 0;
    for (int k = 0; k <= bcs[i]; k++) begin
      if (k < bcs[i]) begin
        par = 0;
        foreach (offs[j]) if (offs[j] <= k) par ^= 1;
        ey = y0 ^ par[0];
      end else begin
        ey = lvl;
      end
      check("bounce_y", 32'(y_v[i]), 32'(ey));
      check("bounce_settled", 32'(settled_v[i]), 32'(k == bcs[i]));
      check("bounce_ready", 32'(ready_v[i]), 0);
      if (y_v[i] != prev) nedge++;
      prev = y_v[i];
      if (k == bcs[i]) break;
      if (noise) begin
        req_v[i]   = 1'($urandom);
        level_v[i] = 1'($urandom);
      end else begin
        req_v[i] = 1'b0;
      end
      @(negedge clk);
    end
    exp_cnt = ntog + ((y0 ^ 1'(ntog)) != lvl ? 1 : 0);
    if (exp_cnt > 255) exp_cnt = 255;
    check("final_count", 32'(bc_v[i]), 32'(exp_cnt));
    if (nedge < 255) check("count_vs_edges", 32'(bc_v[i]), 32'(nedge));
    req_v[i] = 1'b0;
    @(negedge clk);
    check("ready_after_settle", 32'(ready_v[i]), 1);
    check("settled_after", 32'(settled_v[i]), 0);
    check("y_hold_after", 32'(y_v[i]), 32'(lvl));
    check("count_frozen", 32'(bc_v[i]), 32'(exp_cnt));
    m_y[i] = lvl;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_v[i] = 1'b1;
      req_v[i] = 1'b0;
      level_v[i] = 1'b0;
      m_y[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check_reset_state(0);
    check_reset_state(1);
    rst_v[0] = 1'b0;
    rst_v[1] = 1'b0;
    idle(0, 2);

    do_op(0, 1'b1, 1'b0);
    do_op(0, 1'b0, 1'b0);
    do_op(0, 1'b0, 1'b0);
    do_op(0, 1'b1, 1'b1);
    do_op(0, 1'b1, 1'b1);
    for (int n = 0; n < 25; n++) begin
      idle(0, $urandom_range(0, 3));
      do_op(0, 1'($urandom), 1'($urandom));
    end

    // Abort mid-bounce with a 3-cycle reset, then repeat a press from reset.
    req_v[0]   = 1'b1;
    level_v[0] = ~m_y[0];
    @(negedge clk);
    req_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_v[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_reset_state(0);
    end
    rst_v[0] = 1'b0;
    m_y[0]   = 1'b0;
    @(negedge clk);
    check_reset_state(0);
    do_op(0, 1'b1, 1'b0);
    do_op(0, 1'b0, 1'b1);

    do_op(1, 1'b1, 1'b0);
    check("saturated", 32'(bc_v[1]), 255);
    idle(1, 2);
    do_op(1, 1'b0, 1'b1);
    do_op(1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
